// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage: occupancy encoding and the NOP control value.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Replicated to CTRL_W wherever a bubble is needed.
  localparam logic CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register; clear_ctrl_i kills the entry but keeps data.
// Single-cycle update. No handshake of its own: the parent stage decides when to load or clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_ctrl_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clear wins over load so a flush always leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      ctrl_q <= {CTRL_W{CTRL_NOP}};
      data_q <= '0;
    end else if (clear_ctrl_i) begin
      vld_q  <= 1'b0;
      ctrl_q <= {CTRL_W{CTRL_NOP}};
    end else if (load_i) begin
      vld_q  <= 1'b1;
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register with 2-entry skid buffer: 1-cycle latency, full throughput, registered in_ready.
// Optional stall/flush performance counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  occ_e state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic acc, pop;

  logic              head_load, head_clr, head_sel_skid;
  logic              skid_load, skid_clr;
  logic              head_vld, skid_vld;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
  logic [DATA_W-1:0] head_data, skid_data, head_data_in;

  assign acc = in_valid & in_ready_q;
  assign pop = head_vld & out_ready;

  always_comb begin
    state_d       = state_q;
    head_load     = 1'b0;
    head_clr      = 1'b0;
    head_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_d  = OCC_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (acc) begin
            head_load = 1'b1;
            state_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && pop) begin
            head_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_d   = OCC_TWO;
          end else if (pop) begin
            head_clr = 1'b1;
            state_d  = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop && skid_vld) begin
            head_load     = 1'b1;
            head_sel_skid = 1'b1;
            skid_clr      = 1'b1;
            state_d       = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
    // Skid holds an entry exactly when the next state is TWO.
    in_ready_d = (state_d != OCC_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign head_ctrl_in = head_sel_skid ? skid_ctrl : in_ctrl;
  assign head_data_in = head_sel_skid ? skid_data : in_data;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk          (clk),
    .reset        (reset),
    .load_i       (head_load),
    .clear_ctrl_i (head_clr),
    .ctrl_i       (head_ctrl_in),
    .data_i       (head_data_in),
    .vld_o        (head_vld),
    .ctrl_o       (head_ctrl),
    .data_o       (head_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk          (clk),
    .reset        (reset),
    .load_i       (skid_load),
    .clear_ctrl_i (skid_clr),
    .ctrl_i       (in_ctrl),
    .data_i       (in_data),
    .vld_o        (skid_vld),
    .ctrl_o       (skid_ctrl),
    .data_o       (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = head_vld;
  assign out_ctrl  = head_vld ? head_ctrl : {CTRL_W{CTRL_NOP}};
  assign out_data  = head_data;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (head_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (state_q != OCC_EMPTY) && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios then randomized valid/ready/flush/reset traffic.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

`ifndef PIPE_STAGE_PERF_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: the stage is a FIFO of capacity two, emptied by flush or reset.
  ent_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   pops    = 0;
  int   stall_m = 0;
  int   flush_m = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      chk("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      if (!out_valid)
        chk("nop_ctrl", 64'(out_ctrl), 64'd0);
      if (exp_q.size() != 0) begin
        chk("head_data", 64'(out_data), 64'(exp_q[0].data));
        chk("head_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic cycle(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy, input bit fl, input bit rst);
    int   sz;
    ent_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    sz        = exp_q.size();
    @(negedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (sz > 0 && !ordy && stall_m != 65535) stall_m++;
      if (fl && sz > 0 && flush_m != 65535) flush_m++;
      if (fl) begin
        exp_q.delete();
      end else if (v && sz < 2) begin
        e.ctrl = c;
        e.data = d;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_ctrl"}, 64'(out_ctrl), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_occupancy"}, {62'd0, occupancy}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
  endtask

  initial begin
    int p0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;
    check_reset_vals("por");

    // 1: single entry appears one cycle later
    cycle(1, 16'h1, 32'h100, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_out_data", 64'(out_data), 64'h100);
    chk("t1_occupancy", {62'd0, occupancy}, 64'd1);
    chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
    cycle(0, 0, 0, 1, 0, 0);

    // 2: streaming at full rate
    p0 = pops;
    for (int i = 1; i <= 8; i++) cycle(1, 16'(i), 32'(i), 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("t2_pop_count", 64'(pops - p0), 64'd8);

    // 3: fill skid under back-pressure, then drain
    cycle(1, 16'h7, 32'hA, 0, 0, 0);
    cycle(1, 16'h8, 32'hB, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t3_occupancy", {62'd0, occupancy}, 64'd2);
    chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t3_held_data", 64'(out_data), 64'hA);
    cycle(0, 0, 0, 1, 0, 0);
    chk("t3_first_pop", 64'(out_data), 64'hA);
    cycle(0, 0, 0, 1, 0, 0);
    chk("t3_second_pop", 64'(out_data), 64'hB);
    chk("t3_in_ready_back", {63'd0, in_ready}, 64'd1);
    cycle(0, 0, 0, 1, 0, 0);

    // 4: flush with both slots full and a new entry offered
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 16'h5, 32'hC, 0, 0, 0);
    cycle(1, 16'h6, 32'hD, 0, 0, 0);
    cycle(1, 16'h3, 32'hE, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t4_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("t4_occupancy", {62'd0, occupancy}, 64'd0);
    chk("t4_in_ready", {63'd0, in_ready}, 64'd1);
    chk("t4_data_retained", 64'(out_data), 64'hC);
`ifdef PIPE_STAGE_PERF_EN
    chk("t4_flush_cnt", 64'(flush_cnt), 64'd1);
`endif

    // 5: five stall cycles, then reset mid-burst
    cycle(1, 16'h9, 32'h55, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 16'h9, 32'h56 + 32'(i), 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("t5_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    cycle(0, 0, 0, 0, 0, 0);
    check_reset_vals("t5_reset");

    // 6: random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
            $urandom_range(0, 999) < 2);
`ifdef PIPE_STAGE_PERF_EN
      if (i % 500 == 0) begin
        chk("rnd_stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("rnd_flush_cnt", 64'(flush_cnt), 64'(flush_m));
      end
`endif
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("final_empty", 64'(exp_q.size()), {62'd0, occupancy});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
